id_ex_operand_stage: RTL and testbench

- Decode-side consumer of the register file read ports. Captures the ID-stage instruction's operands and control into the ID/EX pipeline register.
- Bypasses MEM-stage results into operands read this cycle. The register file's negedge write already covers WB-stage results, so no WB bypass is needed.
- Detects load-use hazards, inserts bubbles, and handles branch flushes and pipeline holds.
- Sits between the register file / decoder and the EX stage.

---
 rtl/id_ex_operand_stage_if.sv | 53 +++++
 rtl/id_ex_operand_stage.sv | 91 +++++++++
 tb/tb_id_ex_operand_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Bundles the ID-side operand/control inputs, MEM bypass, pipeline control and ID/EX outputs.
// Latency: n/a (wiring only).
// Backpressure: carries hold/flush in and stall_if_id out; no handshake of its own.
interface id_ex_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    // ID stage instruction and register file read data
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic [ADDR_W-1:0] id_rd;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [7:0]        id_ctrl;

    // MEM stage result available for bypass
    logic              mem_reg_write;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_result;

    // pipeline control
    logic              flush;
    logic              hold;
    logic              stall_if_id;

    // ID/EX register contents
    logic              ex_valid;
    logic [7:0]        ex_ctrl;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic [DATA_W-1:0] ex_imm;
    logic [ADDR_W-1:0] ex_rs;
    logic [ADDR_W-1:0] ex_rt;
    logic [ADDR_W-1:0] ex_waddr;

    // driver side: decoder / regfile / pipeline control, consumer of EX fields
    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl,
        output mem_reg_write, mem_waddr, mem_result, flush, hold,
        input  stall_if_id,
        input  ex_valid, ex_ctrl, ex_op1, ex_op2, ex_imm, ex_rs, ex_rt, ex_waddr
    );

    // the operand stage itself
    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl,
        input  mem_reg_write, mem_waddr, mem_result, flush, hold,
        output stall_if_id,
        output ex_valid, ex_ctrl, ex_op1, ex_op2, ex_imm, ex_rs, ex_rt, ex_waddr
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand capture with MEM bypass, load-use bubble insertion, flush and hold.
// Latency: 1 cycle from ID inputs to ex_* outputs; stall_if_id is combinational.
// Backpressure: hold freezes ID/EX; load-use or hold raises stall_if_id unless flush is set.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_operand_stage_if.slave  bus
);

    // id_ctrl / ex_ctrl bit positions
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 3;

    typedef struct packed {
        logic              valid;
        logic [7:0]        ctrl;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] waddr;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_load;
    logic    byp1;
    logic    byp2;
    logic    load_use;

    // MEM-stage bypass; r0 is excluded so it always reads as zero.
    // WB results need no bypass since the regfile writes them on the negedge.
    always_comb begin
        byp1 = bus.mem_reg_write && (bus.mem_waddr != '0) && (bus.mem_waddr == bus.id_rs);
        byp2 = bus.mem_reg_write && (bus.mem_waddr != '0) && (bus.mem_waddr == bus.id_rt);
    end

    // Candidate ID/EX contents for a normal load; invalid instructions carry no control.
    always_comb begin
        ex_load       = '0;
        ex_load.valid = bus.id_valid;
        ex_load.ctrl  = bus.id_valid ? bus.id_ctrl : 8'h00;
        ex_load.op1   = byp1 ? bus.mem_result : bus.id_rdata1;
        ex_load.op2   = byp2 ? bus.mem_result : bus.id_rdata2;
        ex_load.imm   = bus.id_imm;
        ex_load.rs    = bus.id_rs;
        ex_load.rt    = bus.id_rt;
        ex_load.waddr = bus.id_ctrl[CTRL_REG_DST] ? bus.id_rd : bus.id_rt;
    end

    // Load in EX whose destination is a source of the ID instruction; rt only counts
    // as a source when the ALU takes its second operand from the register file.
    always_comb begin
        load_use = bus.id_valid && ex_q.valid && ex_q.ctrl[CTRL_MEM_TO_REG] &&
                   (ex_q.waddr != '0) &&
                   ((ex_q.waddr == bus.id_rs) ||
                    ((ex_q.waddr == bus.id_rt) && !bus.id_ctrl[CTRL_ALU_SRC]));
        // A taken branch discards the fetched path, so there is nothing to freeze.
        bus.stall_if_id = (load_use || bus.hold) && !bus.flush;
    end

    // ID/EX register: flush beats hold beats load-use bubble beats normal load.
    // Hold keeps state even with a pending hazard; it is re-evaluated after hold drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (bus.hold) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_load;
        end
    end

    assign bus.ex_valid = ex_q.valid;
    assign bus.ex_ctrl  = ex_q.ctrl;
    assign bus.ex_op1   = ex_q.op1;
    assign bus.ex_op2   = ex_q.op2;
    assign bus.ex_imm   = ex_q.imm;
    assign bus.ex_rs    = ex_q.rs;
    assign bus.ex_rt    = ex_q.rt;
    assign bus.ex_waddr = ex_q.waddr;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus random traffic.
// Latency: expects ex_* one posedge after ID inputs are driven.
// Backpressure: drives hold/flush directly and checks stall_if_id every cycle.
module tb_id_ex_operand_stage;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    id_ex_operand_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          vld;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] rd1, rd2, imm;
        logic [7:0]    ctrl;
        logic          mwr;
        logic [AW-1:0] mwa;
        logic [DW-1:0] mres;
        logic          flush, hold;
    } stim_t;

    typedef struct {
        logic          vld;
        logic [7:0]    ctrl;
        logic [DW-1:0] op1, op2, imm;
        logic [AW-1:0] rs, rt, waddr;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t mdl;
    logic st;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.vld = 1'b0; e.ctrl = '0; e.op1 = '0; e.op2 = '0; e.imm = '0;
        e.rs = '0; e.rt = '0; e.waddr = '0;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.vld = 1'b0; s.rs = '0; s.rt = '0; s.rd = '0;
        s.rd1 = '0; s.rd2 = '0; s.imm = '0; s.ctrl = '0;
        s.mwr = 1'b0; s.mwa = '0; s.mres = '0;
        s.flush = 1'b0; s.hold = 1'b0;
        return s;
    endfunction

    function automatic stim_t instr(input logic [7:0] ctrl, input logic [AW-1:0] rs,
                                    input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                                    input logic [DW-1:0] rd1, input logic [DW-1:0] rd2);
        stim_t s;
        s = idle();
        s.vld = 1'b1; s.ctrl = ctrl; s.rs = rs; s.rt = rt; s.rd = rd;
        s.rd1 = rd1; s.rd2 = rd2; s.imm = 32'h0000_0100 + DW'(rd);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_valid      = s.vld;
        bus.id_rs         = s.rs;
        bus.id_rt         = s.rt;
        bus.id_rd         = s.rd;
        bus.id_rdata1     = s.rd1;
        bus.id_rdata2     = s.rd2;
        bus.id_imm        = s.imm;
        bus.id_ctrl       = s.ctrl;
        bus.mem_reg_write = s.mwr;
        bus.mem_waddr     = s.mwa;
        bus.mem_result    = s.mres;
        bus.flush         = s.flush;
        bus.hold          = s.hold;
    endtask

    task automatic compare_ex(input exp_t e);
        check("ex_valid", 64'(bus.ex_valid), 64'(e.vld));
        check("ex_ctrl",  64'(bus.ex_ctrl),  64'(e.ctrl));
        check("ex_op1",   64'(bus.ex_op1),   64'(e.op1));
        check("ex_op2",   64'(bus.ex_op2),   64'(e.op2));
        check("ex_imm",   64'(bus.ex_imm),   64'(e.imm));
        check("ex_rs",    64'(bus.ex_rs),    64'(e.rs));
        check("ex_rt",    64'(bus.ex_rt),    64'(e.rt));
        check("ex_waddr", 64'(bus.ex_waddr), 64'(e.waddr));
    endtask

    // Drive one ID cycle, check the stall, predict the ID/EX register, clock, compare.
    task automatic step(input stim_t s, output logic stall_obs);
        exp_t          nxt;
        exp_t          got;
        logic          lu;
        logic          exp_stall;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        apply(s);
        #1;
        op1 = (s.mwr && s.mwa != 0 && s.mwa == s.rs) ? s.mres : s.rd1;
        op2 = (s.mwr && s.mwa != 0 && s.mwa == s.rt) ? s.mres : s.rd2;
        lu  = s.vld && mdl.vld && mdl.ctrl[6] && (mdl.waddr != 0) &&
              ((mdl.waddr == s.rs) || ((mdl.waddr == s.rt) && !s.ctrl[4]));
        exp_stall = (lu || s.hold) && !s.flush;
        stall_obs = bus.stall_if_id;
        check("stall_if_id", 64'(stall_obs), 64'(exp_stall));
        if (s.flush) begin
            nxt = zero_exp();
        end else if (s.hold) begin
            nxt = mdl;
        end else if (lu) begin
            nxt = zero_exp();
        end else begin
            nxt.vld   = s.vld;
            nxt.ctrl  = s.vld ? s.ctrl : 8'h00;
            nxt.op1   = op1;
            nxt.op2   = op2;
            nxt.imm   = s.imm;
            nxt.rs    = s.rs;
            nxt.rt    = s.rt;
            nxt.waddr = s.ctrl[3] ? s.rd : s.rt;
        end
        mdl = nxt;
        sb_q.push_back(nxt);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            compare_ex(got);
        end
    endtask

    initial begin
        stim_t s;
        mdl = zero_exp();
        apply(idle());

        // reset state
        #2;
        check("rst_valid", 64'(bus.ex_valid), 64'd0);
        check("rst_ctrl",  64'(bus.ex_ctrl),  64'd0);
        check("rst_op1",   64'(bus.ex_op1),   64'd0);
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load a valid instruction, then assert reset between edges
        step(instr(8'h88, 5'd1, 5'd2, 5'd3, 32'h0000_00AA, 32'h0000_00BB), st);
        check("pre_rst_valid", 64'(bus.ex_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.ex_valid), 64'd0);
        check("async_rst_ctrl",  64'(bus.ex_ctrl),  64'd0);
        check("async_rst_op1",   64'(bus.ex_op1),   64'd0);
        check("async_rst_waddr", 64'(bus.ex_waddr), 64'd0);
        mdl = zero_exp();
        sb_q.delete();
        #1 rst_n = 1'b1;
        step(instr(8'h88, 5'd1, 5'd2, 5'd3, 32'h0000_0011, 32'h0000_0022), st);
        check("post_rst_op1", 64'(bus.ex_op1), 64'h11);

        // MEM bypass, and r0 is never bypassed
        s = instr(8'h88, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2);
        s.mwr = 1'b1; s.mwa = 5'd5; s.mres = 32'hDEAD_BEEF;
        step(s, st);
        check("byp_op1", 64'(bus.ex_op1), 64'hDEAD_BEEF);
        check("byp_op2", 64'(bus.ex_op2), 64'h2);
        s = instr(8'h88, 5'd0, 5'd6, 5'd7, 32'h0, 32'h2);
        s.mwr = 1'b1; s.mwa = 5'd0; s.mres = 32'hDEAD_BEEF;
        step(s, st);
        check("byp_r0_op1", 64'(bus.ex_op1), 64'h0);

        // load-use: lw writes r8, consumer reads rs=8
        step(instr(8'hC0, 5'd1, 5'd8, 5'd0, 32'h10, 32'h0), st);
        step(instr(8'h88, 5'd8, 5'd2, 5'd9, 32'h55, 32'h66), st);
        check("lu_stall", 64'(st), 64'd1);
        check("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
        check("lu_bubble_ctrl",  64'(bus.ex_ctrl),  64'd0);
        step(instr(8'h88, 5'd8, 5'd2, 5'd9, 32'h55, 32'h66), st);
        check("lu_retry_stall", 64'(st), 64'd0);
        check("lu_retry_valid", 64'(bus.ex_valid), 64'd1);
        check("lu_retry_op1",   64'(bus.ex_op1),   64'h55);

        // alu_src=1: rt is not a source, no hazard
        step(instr(8'hC0, 5'd1, 5'd8, 5'd0, 32'h10, 32'h0), st);
        step(instr(8'h90, 5'd3, 5'd8, 5'd0, 32'h33, 32'h44), st);
        check("alusrc_stall", 64'(st), 64'd0);
        check("alusrc_valid", 64'(bus.ex_valid), 64'd1);

        // flush wins over hold and a load-use hazard
        step(instr(8'hC0, 5'd1, 5'd8, 5'd0, 32'h10, 32'h0), st);
        s = instr(8'h88, 5'd8, 5'd2, 5'd9, 32'h55, 32'h66);
        s.flush = 1'b1; s.hold = 1'b1;
        step(s, st);
        check("flush_stall", 64'(st), 64'd0);
        check("flush_valid", 64'(bus.ex_valid), 64'd0);
        check("flush_ctrl",  64'(bus.ex_ctrl),  64'd0);

        // hold for 3 cycles with changing ID inputs
        step(instr(8'h88, 5'd4, 5'd5, 5'd6, 32'hAAAA, 32'hBBBB), st);
        for (int i = 0; i < 3; i++) begin
            s = instr(8'h88, 5'(10 + i), 5'(11 + i), 5'(12 + i), 32'(i + 100), 32'(i + 200));
            s.hold = 1'b1;
            step(s, st);
            check("hold_stall", 64'(st), 64'd1);
            check("hold_op1",   64'(bus.ex_op1), 64'hAAAA);
            check("hold_waddr", 64'(bus.ex_waddr), 64'd6);
        end
        step(instr(8'h80, 5'd7, 5'd9, 5'd1, 32'h7777, 32'h9999), st);
        check("hold_rel_op1",   64'(bus.ex_op1),   64'h7777);
        check("hold_rel_waddr", 64'(bus.ex_waddr), 64'd9);

        // hold with a pending hazard: no extra bubble, hazard re-evaluated afterwards
        step(instr(8'hC0, 5'd1, 5'd8, 5'd0, 32'h10, 32'h0), st);
        s = instr(8'h88, 5'd8, 5'd2, 5'd9, 32'h55, 32'h66);
        s.hold = 1'b1;
        step(s, st);
        check("holdlu_ctrl", 64'(bus.ex_ctrl), 64'hC0);
        step(instr(8'h88, 5'd8, 5'd2, 5'd9, 32'h55, 32'h66), st);
        check("holdlu_stall", 64'(st), 64'd1);
        check("holdlu_bubble", 64'(bus.ex_valid), 64'd0);

        // invalid ID instruction carries no control
        s = instr(8'hFF, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
        s.vld = 1'b0;
        step(s, st);
        check("inv_ctrl",  64'(bus.ex_ctrl),  64'd0);
        check("inv_valid", 64'(bus.ex_valid), 64'd0);

        // random traffic against the scoreboard
        for (int n = 0; n < 300; n++) begin
            logic [7:0] c;
            case ($urandom_range(0, 4))
                0:       c = 8'hC0;
                1:       c = 8'h88;
                2:       c = 8'h90;
                3:       c = 8'h30;
                default: c = 8'($urandom);
            endcase
            s = instr(c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), $urandom, $urandom);
            s.vld   = ($urandom_range(0, 5) != 0);
            s.imm   = $urandom;
            s.mwr   = 1'($urandom);
            s.mwa   = 5'($urandom_range(0, 7));
            s.mres  = $urandom;
            s.flush = ($urandom_range(0, 7) == 0);
            s.hold  = ($urandom_range(0, 4) == 0);
            step(s, st);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
